// File: rtl/ccip_mmio_csr_responder.sv
// CCI-P MMIO responder: decodes c0 MMIO reads/writes against a small CSR file
// and returns tid-tagged c2 read responses after a fixed pipeline latency.
module ccip_mmio_csr_responder #(
    parameter logic [63:0] AFU_DFH    = 64'h1000_0000_0000_1001,
    parameter logic [63:0] AFU_ID_L   = 64'h0,
    parameter logic [63:0] AFU_ID_H   = 64'h0,
    parameter int          RD_LATENCY = 2
) (
    input  logic        vl_clk_LPdomain_16ui,
    input  logic        ffs_LP16ui_afu_SoftReset,
    input  logic        rx_mmio_rd_valid,
    input  logic        rx_mmio_wr_valid,
    input  logic [15:0] rx_mmio_addr,
    input  logic [1:0]  rx_mmio_len,
    input  logic [8:0]  rx_mmio_tid,
    input  logic [63:0] rx_mmio_data,
    input  logic [63:0] afu_status,
    output logic        tx_mmio_rsp_valid,
    output logic [8:0]  tx_mmio_rsp_tid,
    output logic [63:0] tx_mmio_rsp_data,
    output logic [63:0] csr_ctrl,
    output logic [63:0] csr_scratch,
    output logic        err_unaligned
);

    localparam logic [14:0] QW_DFH     = 15'h00;
    localparam logic [14:0] QW_ID_L    = 15'h01;
    localparam logic [14:0] QW_ID_H    = 15'h02;
    localparam logic [14:0] QW_SCRATCH = 15'h08;
    localparam logic [14:0] QW_CTRL    = 15'h09;
    localparam logic [14:0] QW_STATUS  = 15'h0A;
    localparam logic [14:0] QW_CYCLE   = 15'h0B;
    localparam logic [14:0] QW_WRCNT   = 15'h0C;
    localparam int          LAST       = RD_LATENCY - 1;

    logic clk;
    logic rst;
    assign clk = vl_clk_LPdomain_16ui;
    assign rst = ffs_LP16ui_afu_SoftReset;

    logic [63:0] scratch_q, scratch_d;
    logic [63:0] ctrl_q, ctrl_d;
    logic [63:0] cycleCnt_q, cycleCnt_d;
    logic [31:0] wrCnt_q, wrCnt_d;
    logic        errUnaligned_q, errUnaligned_d;

    logic [RD_LATENCY-1:0] rspVld_q;
    logic [8:0]            rspTid_q  [RD_LATENCY];
    logic [63:0]           rspData_q [RD_LATENCY];

    logic [14:0] qwIdx;
    logic        hiHalf;
    logic        isWide;
    logic        unaligned;
    logic [63:0] regVal;
    logic [63:0] rdData;
    logic        wrAccept;
    logic [63:0] wrOld;
    logic [63:0] wrMerged;
    logic        clrPulse;

    // A DWORD address selects an 8B register by its upper bits; bit0 picks the half.
    assign qwIdx     = rx_mmio_addr[15:1];
    assign hiHalf    = rx_mmio_addr[0];
    assign isWide    = (rx_mmio_len != 2'd0);
    assign unaligned = isWide && hiHalf;
    assign wrAccept  = rx_mmio_wr_valid && !unaligned;

    always_comb begin
        regVal = 64'h0;
        case (qwIdx)
            QW_DFH:     regVal = AFU_DFH;
            QW_ID_L:    regVal = AFU_ID_L;
            QW_ID_H:    regVal = AFU_ID_H;
            QW_SCRATCH: regVal = scratch_q;
            QW_CTRL:    regVal = ctrl_q;
            QW_STATUS:  regVal = afu_status;
            QW_CYCLE:   regVal = cycleCnt_q;
            QW_WRCNT:   regVal = {32'h0, wrCnt_q};
            default:    regVal = 64'h0;
        endcase

        rdData = 64'h0;
        if (!unaligned) begin
            if (isWide) begin
                rdData = regVal;
            end else if (hiHalf) begin
                rdData = {32'h0, regVal[63:32]};
            end else begin
                rdData = {32'h0, regVal[31:0]};
            end
        end
    end

    // Only SCRATCH and CTRL are writable, so the merge source is one of those two.
    always_comb begin
        wrOld = (qwIdx == QW_CTRL) ? ctrl_q : scratch_q;
        if (isWide) begin
            wrMerged = rx_mmio_data;
        end else if (hiHalf) begin
            wrMerged = {rx_mmio_data[31:0], wrOld[31:0]};
        end else begin
            wrMerged = {wrOld[63:32], rx_mmio_data[31:0]};
        end

        clrPulse  = wrAccept && (qwIdx == QW_CTRL) && wrMerged[1];
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        if (wrAccept && (qwIdx == QW_SCRATCH)) begin
            scratch_d = wrMerged;
        end
        if (wrAccept && (qwIdx == QW_CTRL)) begin
            ctrl_d = wrMerged & ~64'h2;
        end

        cycleCnt_d = clrPulse ? 64'h0 : cycleCnt_q + 64'd1;
        if (clrPulse) begin
            wrCnt_d = 32'h0;
        end else if (rx_mmio_wr_valid) begin
            wrCnt_d = wrCnt_q + 32'd1;
        end else begin
            wrCnt_d = wrCnt_q;
        end

        errUnaligned_d = errUnaligned_q | (unaligned && (rx_mmio_rd_valid || rx_mmio_wr_valid));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch_q      <= 64'h0;
            ctrl_q         <= 64'h0;
            cycleCnt_q     <= 64'h0;
            wrCnt_q        <= 32'h0;
            errUnaligned_q <= 1'b0;
        end else begin
            scratch_q      <= scratch_d;
            ctrl_q         <= ctrl_d;
            cycleCnt_q     <= cycleCnt_d;
            wrCnt_q        <= wrCnt_d;
            errUnaligned_q <= errUnaligned_d;
        end
    end

    // Response shift pipeline; idle slots carry zero so the c2 bus stays quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspVld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rspTid_q[i]  <= 9'h0;
                rspData_q[i] <= 64'h0;
            end
        end else begin
            rspVld_q[0]  <= rx_mmio_rd_valid;
            rspTid_q[0]  <= rx_mmio_rd_valid ? rx_mmio_tid : 9'h0;
            rspData_q[0] <= rx_mmio_rd_valid ? rdData : 64'h0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rspVld_q[i]  <= rspVld_q[i-1];
                rspTid_q[i]  <= rspTid_q[i-1];
                rspData_q[i] <= rspData_q[i-1];
            end
        end
    end

    assign tx_mmio_rsp_valid = rspVld_q[LAST];
    assign tx_mmio_rsp_tid   = rspTid_q[LAST];
    assign tx_mmio_rsp_data  = rspData_q[LAST];
    assign csr_ctrl          = ctrl_q;
    assign csr_scratch       = scratch_q;
    assign err_unaligned     = errUnaligned_q;

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Bench for ccip_mmio_csr_responder: directed CSR scenarios followed by random
// traffic, all checked every cycle against a register-map model.
module tb_ccip_mmio_csr_responder;

    localparam int          RD_LATENCY = 2;
    localparam logic [63:0] AFU_DFH    = 64'h1000_0000_0000_1001;

    typedef struct {
        int          due;
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;

    logic        clock = 1'b0;
    logic        rst;
    logic        rdValid, wrValid;
    logic [15:0] addr;
    logic [1:0]  len;
    logic [8:0]  tid;
    logic [63:0] wdata, status;
    logic        rspValid;
    logic [8:0]  rspTid;
    logic [63:0] rspData, csrCtrl, csrScratch;
    logic        errUnaligned;

    logic [63:0] mScratch, mCtrl, mCycle;
    logic [31:0] mWrCnt;
    logic        mErr;
    logic [63:0] lastExpData;
    logic        rstPrev;
    logic        checking = 1'b0;
    logic        expV;
    int          cycleNo  = 0;
    int          nChecks  = 0;
    int          nErrors  = 0;
    rsp_t        expQ[$];
    logic [8:0]  seenTids[$];
    int          seenCycles[$];

    ccip_mmio_csr_responder #(.RD_LATENCY(RD_LATENCY)) dut (
        .vl_clk_LPdomain_16ui     (clock),
        .ffs_LP16ui_afu_SoftReset (rst),
        .rx_mmio_rd_valid         (rdValid),
        .rx_mmio_wr_valid         (wrValid),
        .rx_mmio_addr             (addr),
        .rx_mmio_len              (len),
        .rx_mmio_tid              (tid),
        .rx_mmio_data             (wdata),
        .afu_status               (status),
        .tx_mmio_rsp_valid        (rspValid),
        .tx_mmio_rsp_tid          (rspTid),
        .tx_mmio_rsp_data         (rspData),
        .csr_ctrl                 (csrCtrl),
        .csr_scratch              (csrScratch),
        .err_unaligned            (errUnaligned)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleNo++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Register map seen by a read, keyed by the 8B-aligned byte offset.
    function automatic logic [63:0] regAt(input int qByte, input logic [63:0] st);
        case (qByte)
            'h000:   return AFU_DFH;
            'h040:   return mScratch;
            'h048:   return mCtrl;
            'h050:   return st;
            'h058:   return mCycle;
            'h060:   return {32'h0, mWrCnt};
            default: return 64'h0;
        endcase
    endfunction

    // Drives one request cycle and advances the model to the state after the edge.
    task automatic applyStimulus(input logic r, input logic rd, input logic wr, input logic [15:0] a,
                                 input logic [1:0] l, input logic [8:0] t, input logic [63:0] d,
                                 input logic [63:0] s);
        int          byteAddr;
        int          qByte;
        logic        hi, wide, clr;
        logic [63:0] rv, nv;
        rsp_t        e;
        rst = r; rdValid = rd; wrValid = wr; addr = a; len = l; tid = t; wdata = d; status = s;
        if (r && !rstPrev) begin
            #1;
            checkOutput("rsp_valid_at_reset", 64'(rspValid), 64'h0);
        end
        rstPrev = r;
        if (r) begin
            mScratch = 0; mCtrl = 0; mCycle = 0; mWrCnt = 0; mErr = 0;
            expQ.delete();
        end else begin
            byteAddr = int'(a) * 4;
            qByte    = byteAddr - (byteAddr % 8);
            hi       = (byteAddr % 8) != 0;
            wide     = (l != 2'd0);
            clr      = 1'b0;
            if (rd) begin
                if (wide && hi) begin
                    rv   = 64'h0;
                    mErr = 1'b1;
                end else begin
                    rv = regAt(qByte, s);
                    if (!wide) rv = hi ? (rv >> 32) : (rv & 64'h0000_0000_FFFF_FFFF);
                end
                e.due = cycleNo + RD_LATENCY; e.tid = t; e.data = rv;
                expQ.push_back(e);
                lastExpData = rv;
            end
            if (wr) begin
                if (wide && hi) begin
                    mErr = 1'b1;
                end else if (qByte == 'h040 || qByte == 'h048) begin
                    nv = (qByte == 'h040) ? mScratch : mCtrl;
                    if (wide)    nv = d;
                    else if (hi) nv = {d[31:0], nv[31:0]};
                    else         nv = {nv[63:32], d[31:0]};
                    if (qByte == 'h040) begin
                        mScratch = nv;
                    end else begin
                        clr   = nv[1];
                        nv[1] = 1'b0;
                        mCtrl = nv;
                    end
                end
            end
            if (clr) begin
                mCycle = 0;
                mWrCnt = 0;
            end else begin
                mCycle = mCycle + 1;
                if (wr) mWrCnt = mWrCnt + 1;
            end
        end
        @(negedge clock);
        #1;
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0, 64'h0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0, 64'h0);
    endtask

    task automatic doRead(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t);
        applyStimulus(1'b0, 1'b1, 1'b0, a, l, t, 64'h0, {$urandom, $urandom});
    endtask

    task automatic doWrite(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, a, l, 9'h0, d, 64'h0);
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clock) begin
        if (checking) begin
            expV = (expQ.size() > 0) && (expQ[0].due == cycleNo);
            checkOutput("rsp_valid", 64'(rspValid), 64'(expV));
            if (expV) begin
                checkOutput("rsp_tid", 64'(rspTid), 64'(expQ[0].tid));
                checkOutput("rsp_data", rspData, expQ[0].data);
                void'(expQ.pop_front());
            end
            if (rspValid) begin
                seenTids.push_back(rspTid);
                seenCycles.push_back(cycleNo);
            end
            if (rst) begin
                checkOutput("rsp_tid_reset", 64'(rspTid), 64'h0);
                checkOutput("rsp_data_reset", rspData, 64'h0);
            end
            checkOutput("csr_ctrl", csrCtrl, mCtrl);
            checkOutput("csr_scratch", csrScratch, mScratch);
            checkOutput("err_unaligned", 64'(errUnaligned), 64'(mErr));
        end
    end

    initial begin
        rst = 1'b1; rstPrev = 1'b1;
        rdValid = 0; wrValid = 0; addr = 0; len = 0; tid = 0; wdata = 0; status = 0;
        mScratch = 0; mCtrl = 0; mCycle = 0; mWrCnt = 0; mErr = 0; lastExpData = 0;
        checking = 1'b1;

        // Reset state and DFH read latency
        repeat (3) doReset();
        checkOutput("reset_valid", 64'(rspValid), 64'h0);
        checkOutput("reset_tid", 64'(rspTid), 64'h0);
        checkOutput("reset_data", rspData, 64'h0);
        checkOutput("reset_ctrl", csrCtrl, 64'h0);
        checkOutput("reset_scratch", csrScratch, 64'h0);
        checkOutput("reset_err", 64'(errUnaligned), 64'h0);
        doIdle();
        doRead(16'h0000, 2'd1, 9'h1A3);
        checkOutput("dfh_not_early", 64'(rspValid), 64'h0);
        doIdle();
        checkOutput("dfh_valid", 64'(rspValid), 64'h1);
        checkOutput("dfh_tid", 64'(rspTid), 64'h1A3);
        checkOutput("dfh_data", rspData, 64'h1000_0000_0000_1001);

        // Scratch full and half writes
        doWrite(16'h0010, 2'd1, 64'hDEAD_BEEF_0123_4567);
        doRead(16'h0010, 2'd1, 9'h007);
        checkOutput("model_scratch_pin", lastExpData, 64'hDEAD_BEEF_0123_4567);
        doIdle();
        checkOutput("scratch_rd", rspData, 64'hDEAD_BEEF_0123_4567);
        doWrite(16'h0011, 2'd0, 64'h1111_2222_CAFE_F00D);
        doRead(16'h0010, 2'd1, 9'h008);
        doIdle();
        checkOutput("scratch_half_rd", rspData, 64'hCAFE_F00D_0123_4567);
        checkOutput("scratch_image", csrScratch, 64'hCAFE_F00D_0123_4567);

        // Back-to-back reads
        seenTids.delete(); seenCycles.delete();
        for (int t = 1; t <= 5; t++) doRead(16'h0010, 2'd1, 9'(t));
        doIdle(); doIdle();
        checkOutput("b2b_count", 64'(seenTids.size()), 64'd5);
        for (int i = 0; i < 5 && i < seenTids.size(); i++) begin
            checkOutput("b2b_tid", 64'(seenTids[i]), 64'(i + 1));
            checkOutput("b2b_spacing", 64'(seenCycles[i] - seenCycles[0]), 64'(i));
        end

        // Counter clear through CTRL.CLR
        repeat (3) doWrite(16'h0010, 2'd1, 64'h0000_0000_1234_5678);
        doWrite(16'h0012, 2'd1, 64'h2);
        checkOutput("ctrl_clr_not_stored", csrCtrl, 64'h0);
        doRead(16'h0018, 2'd1, 9'h011);
        checkOutput("model_wrcnt_pin", lastExpData, 64'h0);
        doRead(16'h0016, 2'd1, 9'h012);
        checkOutput("model_cycle_pin", lastExpData, 64'h1);
        checkOutput("wrcnt_after_clr", rspData, 64'h0);
        doIdle();
        checkOutput("cycle_after_clr", rspData, 64'h1);

        // Unaligned and unmapped accesses
        checkOutput("err_before", 64'(errUnaligned), 64'h0);
        doRead(16'h0011, 2'd1, 9'h021);
        doIdle();
        checkOutput("unaligned_data", rspData, 64'h0);
        checkOutput("unaligned_err", 64'(errUnaligned), 64'h1);
        doWrite(16'h0010, 2'd1, 64'h0000_0000_0000_00FF);
        doRead(16'h0080, 2'd1, 9'h022);
        doIdle();
        checkOutput("unmapped_valid", 64'(rspValid), 64'h1);
        checkOutput("unmapped_data", rspData, 64'h0);

        // Reset with reads in flight
        doRead(16'h0010, 2'd1, 9'h0AA);
        doRead(16'h0010, 2'd1, 9'h0BB);
        seenTids.delete(); seenCycles.delete();
        repeat (3) doReset();
        repeat (4) doIdle();
        checkOutput("flushed_rsp_count", 64'(seenTids.size()), 64'h0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic        r, rd, wr;
            logic [15:0] a;
            logic [63:0] d;
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 27));
            d  = {$urandom, $urandom};
            d[1] = ($urandom_range(0, 7) == 0);
            applyStimulus(r, rd, wr, a, 2'($urandom_range(0, 3)), 9'($urandom), d, {$urandom, $urandom});
        end

        repeat (5) doIdle();
        checkOutput("queue_drained", 64'(expQ.size()), 64'h0);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
